// File: rtl/ysyx_24110015_wb_pkg.sv
// rtl/ysyx_24110015_wb_pkg.sv - shared types and constants for the write-back unit
package ysyx_24110015_wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_DEPTH      = 2;

  // x0 is never written and never pending
  localparam int REG_ZERO = 0;

  // One buffered result at default widths: destination and value
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_24110015_wb_fifo.sv
// rtl/ysyx_24110015_wb_fifo.sv - in-order result FIFO with count-based full/empty and a combinational head
module ysyx_24110015_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head reads as zero when empty so downstream sees a clean idle bus
  assign head = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_24110015_wb_unit.sv
// rtl/ysyx_24110015_wb_unit.sv - write-back unit: result FIFO into the register file plus pending scoreboard
module ysyx_24110015_wb_unit
  import ysyx_24110015_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  iss_valid,
  input  logic                  iss_wen,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          iss_set;
  logic [EW-1:0] head;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  // Results with nothing to write are consumed without touching the FIFO
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready && in_wen && (in_rd != ZERO_IDX);
  assign pop      = !fifo_empty;

  ysyx_24110015_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_rd, in_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The register file writes the head on the same edge the FIFO pops it
  assign rf_wen   = pop;
  assign rf_waddr = head[EW-1:DATA_WIDTH];
  assign rf_wdata = head[DATA_WIDTH-1:0];

  assign iss_set = iss_valid && iss_wen && (iss_rd != ZERO_IDX);

  // Clear the retiring register first so a same-edge issue of it wins
  always_comb begin
    pending_next = pending;
    if (pop)     pending_next[rf_waddr] = 1'b0;
    if (iss_set) pending_next[iss_rd]   = 1'b1;
    pending_next[REG_ZERO] = 1'b0;
  end

  // Scoreboard state; reset forgets every outstanding writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  assign stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

endmodule

// File: tb/tb_ysyx_24110015_wb_unit.sv
// tb/tb_ysyx_24110015_wb_unit.sv - self-checking bench for the write-back unit
module tb_ysyx_24110015_wb_unit;
  import ysyx_24110015_wb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        iss_valid;
  logic        iss_wen;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  ysyx_24110015_wb_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wen    (in_wen),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .stall     (stall),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  wb_entry_t   exp_q[$];
  logic [31:0] pend_m;

  typedef struct {
    logic        iv;
    logic        iw;
    logic [4:0]  ird;
    logic [31:0] idat;
    logic        sv;
    logic        sw;
    logic [4:0]  srd;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [4:0]  cd;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic iw, input logic [4:0] ird, input logic [31:0] idat,
                       input logic sv, input logic sw, input logic [4:0] srd,
                       input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cd);
    in_valid  = iv;
    in_wen    = iw;
    in_rd     = ird;
    in_data   = idat;
    iss_valid = sv;
    iss_wen   = sw;
    iss_rd    = srd;
    chk_rs1   = c1;
    chk_rs2   = c2;
    chk_rd    = cd;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Called at a negedge: compare against the model, then advance it over the next posedge
  task automatic step(output bit acc);
    wb_entry_t h;
    wb_entry_t nw;
    bit        pop;
    bit        push;
    bit        iss;
    logic [4:0] srd;
    pop = (exp_q.size() != 0);
    h   = '0;
    if (pop) h = exp_q[0];
    check("rf_wen", rf_wen, pop);
    check("rf_waddr", rf_waddr, h.rd);
    check("rf_wdata", rf_wdata, h.data);
    check("in_ready", in_ready, exp_q.size() != DEPTH);
    check("stall", stall, pend_m[chk_rs1] | pend_m[chk_rs2] | pend_m[chk_rd]);
    acc  = in_valid && (exp_q.size() != DEPTH);
    push = acc && in_wen && (in_rd != 5'd0);
    nw.rd   = in_rd;
    nw.data = in_data;
    iss  = iss_valid && iss_wen && (iss_rd != 5'd0);
    srd  = iss_rd;
    assert (!(iss && pend_m[srd])) else $error("protocol: issue to pending rd %0d", srd);
    @(posedge clk);
    if (pop) begin
      pend_m[h.rd] = 1'b0;
      void'(exp_q.pop_front());
    end
    if (push) exp_q.push_back(nw);
    if (iss) pend_m[srd] = 1'b1;
    pend_m[0] = 1'b0;
    #1;
  endtask

  task automatic cyc(output bit acc);
    @(negedge clk);
    step(acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         acc;
    int         n_acc;
    logic [4:0] r;

    tbl[0]  = '{0, 0, 5'd0, 32'h0,        1, 1, 5'd5, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[1]  = '{1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'h0,        1, 1};
    tbl[2]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd5, 5'd0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 1, 1};
    tbl[3]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[4]  = '{1, 1, 5'd1, 32'h11,       0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[5]  = '{1, 1, 5'd2, 32'h22,       0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 5'd1, 32'h11,       0, 1};
    tbl[6]  = '{1, 1, 5'd3, 32'h33,       0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 5'd2, 32'h22,       0, 1};
    tbl[7]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'h33,       0, 1};
    tbl[8]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[9]  = '{1, 1, 5'd0, 32'h7,        0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[10] = '{1, 0, 5'd9, 32'h99,       0, 0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 5'd0, 32'h0,        0, 1};
    tbl[11] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd9, 5'd9, 5'd9, 0, 5'd0, 32'h0,        0, 1};

    pend_m = '0;
    rst_n  = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd5, 5'd6, 5'd7);
    cyc(acc);

    // Reset in the middle of draining: two writers issued, two results in flight
    drive(0, 0, 5'd0, 32'h0,  1, 1, 5'd6, 5'd0, 5'd0, 5'd0);
    cyc(acc);
    drive(1, 1, 5'd6, 32'h66, 1, 1, 5'd7, 5'd0, 5'd0, 5'd0);
    cyc(acc);
    drive(1, 1, 5'd7, 32'h77, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
    cyc(acc);
    drive(0, 0, 5'd0, 32'h0,  0, 0, 5'd0, 5'd7, 5'd0, 5'd0);
    @(negedge clk);
    check("rst_pre_wen", rf_wen, 1);
    check("rst_pre_addr", rf_waddr, 5'd7);
    check("rst_pre_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wen", rf_wen, 0);
    check("rst_addr", rf_waddr, 0);
    check("rst_data", rf_wdata, 0);
    check("rst_stall", stall, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    pend_m = '0;
    #1;
    check("rst_ready", in_ready, 1);
    cyc(acc);
    idle();
    cyc(acc);

    // Single result, back-to-back burst, x0 and no-write results
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].iw, tbl[i].ird, tbl[i].idat, tbl[i].sv, tbl[i].sw, tbl[i].srd,
            tbl[i].c1, tbl[i].c2, tbl[i].cd);
      @(negedge clk);
      check($sformatf("vec%0d_wen", i), rf_wen, tbl[i].e_wen);
      check($sformatf("vec%0d_addr", i), rf_waddr, tbl[i].e_addr);
      check($sformatf("vec%0d_data", i), rf_wdata, tbl[i].e_data);
      check($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
      check($sformatf("vec%0d_ready", i), in_ready, tbl[i].e_ready);
      step(acc);
    end

    // Same-edge clear and set of rd=4: the issue must win
    drive(1, 1, 5'd4, 32'h44, 0, 0, 5'd0, 5'd0, 5'd4, 5'd0);
    cyc(acc);
    drive(0, 0, 5'd0, 32'h0, 1, 1, 5'd4, 5'd0, 5'd4, 5'd4);
    @(negedge clk);
    check("coll_wen", rf_wen, 1);
    check("coll_addr", rf_waddr, 5'd4);
    step(acc);
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd4, 5'd0);
    @(negedge clk);
    check("coll_stall", stall, 1);
    step(acc);
    drive(1, 1, 5'd4, 32'h45, 0, 0, 5'd0, 5'd0, 5'd4, 5'd0);
    cyc(acc);
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd4, 5'd0);
    @(negedge clk);
    check("coll_pop_stall", stall, 1);
    step(acc);
    @(negedge clk);
    check("coll_clear_stall", stall, 0);
    step(acc);

    // Random traffic with gaps until ten results are accepted
    n_acc = 0;
    acc   = 1'b0;
    idle();
    for (int c = 0; c < 400 && n_acc < 10; c++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_wen   = ($urandom_range(0, 5) != 0);
        in_rd    = 5'($urandom_range(0, 31));
        in_data  = $urandom;
      end
      chk_rs1 = 5'($urandom_range(0, 31));
      chk_rs2 = 5'($urandom_range(0, 31));
      r       = 5'($urandom_range(1, 31));
      chk_rd  = r;
      if ($urandom_range(0, 1) == 1 && !pend_m[chk_rs1] && !pend_m[chk_rs2] && !pend_m[r]) begin
        iss_valid = 1'b1;
        iss_wen   = 1'b1;
        iss_rd    = r;
      end else begin
        iss_valid = 1'b0;
        iss_wen   = 1'b0;
        iss_rd    = 5'd0;
      end
      cyc(acc);
      if (acc) n_acc++;
    end
    check("wrap_accepts", n_acc, 10);
    idle();
    repeat (3) cyc(acc);
    check("wrap_drained", rf_wen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
